uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter among N
// byte-stream requesters, with owner-stall and UART-busy timeouts.
module uart_tx_arbiter #(
    parameter int N             = 4,
    parameter int OWNER_TIMEOUT = 1024,
    parameter int BUSY_TIMEOUT  = 4096
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   Req_Valid,
    input  logic [8*N-1:0] Req_Data,
    input  logic [N-1:0]   Req_Last,
    output logic [N-1:0]   Req_Ready,
    output logic [N-1:0]   Grant,
    output logic [7:0]     Tx_Data,
    output logic           Tx_Send,
    input  logic           Tx_Busy,
    output logic           Error,
    output logic [2:0]     Err_Owner
);

    localparam int OCW = $clog2(OWNER_TIMEOUT + 1);
    localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Returns {found, index}: first valid requester searching ptr+1, ptr+2 ... mod N.
    function automatic logic [3:0] rr_pick(input logic [N-1:0] valid, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!res[3] && ((valid & (ONE_HOT0 << idx)) != {N{1'b0}})) begin
                res = {1'b1, 3'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t         state_r, state_s;
    logic [N-1:0]   grant_r, grant_s;
    logic [2:0]     ptr_r, ptr_s;
    logic [2:0]     owner_r, owner_s;
    logic [7:0]     tx_data_r, tx_data_s;
    logic           tx_send_r, tx_send_s;
    logic           last_r, last_s;
    logic           error_r, error_s;
    logic [2:0]     err_owner_r, err_owner_s;
    logic [OCW-1:0] ocnt_r, ocnt_s;
    logic [BCW-1:0] bcnt_r, bcnt_s;

    logic [3:0]     pick_s;
    logic           owner_valid_s;
    logic           owner_last_s;
    logic [7:0]     owner_data_s;

    assign pick_s        = rr_pick(Req_Valid, ptr_r);
    assign owner_valid_s = |(Req_Valid & grant_r);
    assign owner_last_s  = |(Req_Last & grant_r);

    // Byte of the current owner, selected by the one-hot grant.
    always_comb begin
        owner_data_s = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (grant_r[i]) begin
                owner_data_s = owner_data_s | Req_Data[i*8 +: 8];
            end else begin
                owner_data_s = owner_data_s;
            end
        end
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        tx_data_s   = tx_data_r;
        tx_send_s   = tx_send_r;
        last_s      = last_r;
        error_s     = 1'b0;
        err_owner_s = err_owner_r;
        ocnt_s      = ocnt_r;
        bcnt_s      = bcnt_r;
        case (state_r)
            IDLE: begin
                if (pick_s[3]) begin
                    grant_s = ONE_HOT0 << pick_s[2:0];
                    owner_s = pick_s[2:0];
                    ocnt_s  = {OCW{1'b0}};
                    state_s = ACCEPT;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCEPT: begin
                if (owner_valid_s) begin
                    tx_data_s = owner_data_s;
                    last_s    = owner_last_s;
                    tx_send_s = 1'b1;
                    bcnt_s    = {BCW{1'b0}};
                    state_s   = SEND;
                end else if (ocnt_r == OCW'(OWNER_TIMEOUT - 1)) begin
                    grant_s     = {N{1'b0}};
                    ptr_s       = owner_r;
                    error_s     = 1'b1;
                    err_owner_s = owner_r;
                    state_s     = IDLE;
                end else begin
                    ocnt_s = ocnt_r + OCW'(1);
                end
            end
            SEND: begin
                if (Tx_Busy) begin
                    tx_send_s = 1'b0;
                    state_s   = DRAIN;
                end else if (bcnt_r == BCW'(BUSY_TIMEOUT - 1)) begin
                    tx_send_s   = 1'b0;
                    grant_s     = {N{1'b0}};
                    ptr_s       = owner_r;
                    error_s     = 1'b1;
                    err_owner_s = owner_r;
                    state_s     = IDLE;
                end else begin
                    bcnt_s = bcnt_r + BCW'(1);
                end
            end
            DRAIN: begin
                // Non-last bytes keep the grant: other requesters wait for the whole message.
                if (!Tx_Busy) begin
                    if (last_r) begin
                        grant_s = {N{1'b0}};
                        ptr_s   = owner_r;
                        state_s = IDLE;
                    end else begin
                        ocnt_s  = {OCW{1'b0}};
                        state_s = ACCEPT;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s   = IDLE;
                grant_s   = {N{1'b0}};
                tx_send_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            grant_r     <= {N{1'b0}};
            ptr_r       <= 3'(N - 1);
            owner_r     <= 3'd0;
            tx_data_r   <= 8'h00;
            tx_send_r   <= 1'b0;
            last_r      <= 1'b0;
            error_r     <= 1'b0;
            err_owner_r <= 3'd0;
            ocnt_r      <= {OCW{1'b0}};
            bcnt_r      <= {BCW{1'b0}};
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            tx_data_r   <= tx_data_s;
            tx_send_r   <= tx_send_s;
            last_r      <= last_s;
            error_r     <= error_s;
            err_owner_r <= err_owner_s;
            ocnt_r      <= ocnt_s;
            bcnt_r      <= bcnt_s;
        end
    end

    assign Req_Ready = (state_r == ACCEPT) ? grant_r : {N{1'b0}};
    assign Grant     = grant_r;
    assign Tx_Data   = tx_data_r;
    assign Tx_Send   = tx_send_r;
    assign Error     = error_r;
    assign Err_Owner = err_owner_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: bytes are queued as expected
// when loaded into client models and checked as the arbiter presents them to the UART.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int OT = 16;
    localparam int BT = 32;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req_Valid;
    logic [8*N-1:0] Req_Data;
    logic [N-1:0]   Req_Last;
    logic [N-1:0]   Req_Ready;
    logic [N-1:0]   Grant;
    logic [7:0]     Tx_Data;
    logic           Tx_Send;
    logic           Tx_Busy;
    logic           Error;
    logic [2:0]     Err_Owner;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(.N(N), .OWNER_TIMEOUT(OT), .BUSY_TIMEOUT(BT)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_Valid (Req_Valid),
        .Req_Data  (Req_Data),
        .Req_Last  (Req_Last),
        .Req_Ready (Req_Ready),
        .Grant     (Grant),
        .Tx_Data   (Tx_Data),
        .Tx_Send   (Tx_Send),
        .Tx_Busy   (Tx_Busy),
        .Error     (Error),
        .Err_Owner (Err_Owner)
    );

    typedef struct packed {
        logic [7:0]   data;
        logic [N-1:0] grant;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] cbytes[N][16];
    logic       clast[N][16];
    int         cidx[N];
    int         clen[N];
    int         cstop[N];
    int         busy_mode;
    int         uart_delay;
    int         uart_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_clients();
        for (int r = 0; r < N; r++) begin
            if (cidx[r] < clen[r] && cidx[r] < cstop[r]) begin
                Req_Valid[r]       = 1'b1;
                Req_Data[r*8 +: 8] = cbytes[r][cidx[r]];
                Req_Last[r]        = clast[r][cidx[r]];
            end else begin
                Req_Valid[r]       = 1'b0;
                Req_Data[r*8 +: 8] = 8'h00;
                Req_Last[r]        = 1'b0;
            end
        end
    endtask

    task automatic clear_clients();
        for (int r = 0; r < N; r++) begin
            cidx[r]  = 0;
            clen[r]  = 0;
            cstop[r] = 99;
        end
        drive_clients();
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic l);
        cbytes[r][clen[r]] = b;
        clast[r][clen[r]]  = l;
        clen[r]++;
        drive_clients();
    endtask

    task automatic exp_push(input int r, input logic [7:0] b);
        exp_t e;
        e.data  = b;
        e.grant = N'(1) << r;
        exp_q.push_back(e);
    endtask

    // One clock: client handshakes, scoreboard on each new Tx_Send, UART model.
    task automatic tick();
        logic         p_send;
        logic         p_busy;
        logic [N-1:0] acc;
        exp_t         e;
        p_send = Tx_Send;
        p_busy = Tx_Busy;
        acc    = Req_Valid & Req_Ready;
        @(posedge Clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (acc[r]) cidx[r]++;
        end
        if (Tx_Send && !p_send) begin
            check("sb_expected_send", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_tx_data", 32'(Tx_Data), 32'(e.data));
                check("sb_grant", 32'(Grant), 32'(e.grant));
            end
        end
        if (p_send && p_busy) check("send_drop_after_busy", 32'(Tx_Send), 32'd0);
        if (uart_hold > 0) begin
            uart_hold--;
            if (uart_hold == 0) Tx_Busy = 1'b0;
        end else if (busy_mode != 0 && Tx_Send) begin
            uart_delay++;
            if (uart_delay == 2) begin
                Tx_Busy    = 1'b1;
                uart_hold  = 10;
                uart_delay = 0;
            end
        end else begin
            uart_delay = 0;
        end
        drive_clients();
    endtask

    task automatic wait_accepted(input int r, input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (cidx[r] >= n) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output logic ok);
        logic done;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            done = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (cidx[r] < clen[r] && cidx[r] < cstop[r]) done = 1'b0;
            end
            if (done && !Tx_Send && !Tx_Busy) ok = 1'b1;
        end
        tick();
    endtask

    initial begin
        logic ok;
        logic seen;
        int   cnt;
        Reset      = 1'b1;
        Tx_Busy    = 1'b0;
        busy_mode  = 1;
        uart_delay = 0;
        uart_hold  = 0;
        Req_Valid  = '0;
        Req_Data   = '0;
        Req_Last   = '0;
        clear_clients();
        tick();
        tick();
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_tx_send", 32'(Tx_Send), 32'd0);
        check("rst_tx_data", 32'(Tx_Data), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_err_owner", 32'(Err_Owner), 32'd0);
        check("rst_req_ready", 32'(Req_Ready), 32'd0);
        Reset = 1'b0;

        // "HI!" from requester 0
        load(0, 8'h48, 1'b0); exp_push(0, 8'h48);
        load(0, 8'h49, 1'b0); exp_push(0, 8'h49);
        load(0, 8'h21, 1'b1); exp_push(0, 8'h21);
        wait_idle(ok);
        check("t1_done", 32'(ok), 32'd1);
        check("t1_grant_released", 32'(Grant), 32'd0);

        // Requesters 1 and 2 together after reset, two single-byte messages each
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        clear_clients();
        load(1, 8'h31, 1'b1);
        load(1, 8'h33, 1'b1);
        load(2, 8'h32, 1'b1);
        load(2, 8'h34, 1'b1);
        exp_push(1, 8'h31); exp_push(2, 8'h32);
        exp_push(1, 8'h33); exp_push(2, 8'h34);
        wait_idle(ok);
        check("t2_done", 32'(ok), 32'd1);

        // Requester 3 arrives during a 4-byte message from requester 0
        clear_clients();
        for (int k = 0; k < 4; k++) begin
            load(0, 8'hA0 + 8'(k), k == 3);
            exp_push(0, 8'hA0 + 8'(k));
        end
        wait_accepted(0, 1, ok);
        check("t3_first_byte", 32'(ok), 32'd1);
        load(3, 8'hD3, 1'b1); exp_push(3, 8'hD3);
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (Grant == 4'b1000) ok = 1'b1;
            else if (Req_Ready[3]) seen = 1'b1;
        end
        check("t3_grant_to_3", 32'(ok), 32'd1);
        check("t3_ready3_locked_out", 32'(seen), 32'd0);
        check("t3_owner0_drained", 32'(cidx[0]), 32'd4);
        wait_idle(ok);
        check("t3_done", 32'(ok), 32'd1);

        // Owner 2 stalls after its first byte
        clear_clients();
        cstop[2] = 1;
        load(2, 8'hC0, 1'b0); exp_push(2, 8'hC0);
        load(2, 8'hC1, 1'b0);
        load(2, 8'hC2, 1'b1);
        wait_accepted(2, 1, ok);
        check("t4_first_byte", 32'(ok), 32'd1);
        load(3, 8'hE3, 1'b1); exp_push(3, 8'hE3);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (Error) seen = 1'b1;
            else if (Req_Ready[2]) cnt++;
        end
        check("t4_error_seen", 32'(seen), 32'd1);
        check("t4_owner_timeout_cycles", 32'(cnt), 32'(OT));
        check("t4_err_owner", 32'(Err_Owner), 32'd2);
        check("t4_grant_revoked", 32'(Grant), 32'd0);
        tick();
        check("t4_error_one_pulse", 32'(Error), 32'd0);
        wait_idle(ok);
        check("t4_done", 32'(ok), 32'd1);

        // UART never raises Busy
        clear_clients();
        busy_mode = 0;
        load(0, 8'h55, 1'b1); exp_push(0, 8'h55);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (Tx_Send) ok = 1'b1;
        end
        check("t5_send_seen", 32'(ok), 32'd1);
        cnt = 1;
        ok  = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (!Tx_Send) ok = 1'b1;
            else cnt++;
        end
        check("t5_send_dropped", 32'(ok), 32'd1);
        check("t5_send_high_cycles", 32'(cnt), 32'(BT));
        check("t5_error", 32'(Error), 32'd1);
        check("t5_err_owner", 32'(Err_Owner), 32'd0);
        busy_mode = 1;
        load(1, 8'h66, 1'b1); exp_push(1, 8'h66);
        wait_idle(ok);
        check("t5_recover", 32'(ok), 32'd1);

        // Reset while draining a message from requester 3
        clear_clients();
        load(3, 8'h77, 1'b0); exp_push(3, 8'h77);
        load(3, 8'h78, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (Tx_Busy && !Tx_Send && Grant != 4'b0000) ok = 1'b1;
        end
        check("t6_in_drain", 32'(ok), 32'd1);
        Reset = 1'b1;
        tick();
        check("t6_rst_tx_send", 32'(Tx_Send), 32'd0);
        check("t6_rst_grant", 32'(Grant), 32'd0);
        check("t6_rst_error", 32'(Error), 32'd0);
        Reset      = 1'b0;
        Tx_Busy    = 1'b0;
        uart_hold  = 0;
        uart_delay = 0;
        clear_clients();
        load(0, 8'h80, 1'b1);
        load(2, 8'h82, 1'b1);
        exp_push(0, 8'h80); exp_push(2, 8'h82);
        wait_idle(ok);
        check("t6_done", 32'(ok), 32'd1);

        check("sb_all_sent", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
